// File: rtl/hpu_pkg.sv
// Shared defaults and the stream word layout for the get-side input path.
package hpu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 16;
    localparam int CNT_W_DEF  = 16;

    typedef struct packed {
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } stream_word_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage with write/read pointers; head entry is visible combinationally (FWFT).
module sync_fifo_ram #(
    parameter int W     = 33,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/get_stream_buf.sv
// Input buffer ahead of the get stage: valid/ready slave, FIFO, occupancy, beat count, end-of-stream pulse.
module get_stream_buf
    import hpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic                       gen,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    input  logic                       s_last,
    output logic                       get_valid,
    input  logic                       get_ready,
    output logic [DATA_W-1:0]          get_data,
    output logic                       get_last,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [CNT_W-1:0]           beat_cnt,
    output logic                       stream_done
);

    localparam int LW = $clog2(DEPTH+1);

    logic          clr;
    logic          full;
    logic          push;
    logic          pop;
    logic          seen_last;
    logic [DATA_W:0] head;

    // Dropping run flushes exactly like reset so this stage and the get stage restart together.
    assign clr  = rst | ~run;
    assign full = (level == LW'(DEPTH));

    assign s_ready   = ~rst & run & ~gen & ~full & ~seen_last;
    assign get_valid = ~rst & run & (level != '0);
    assign push      = s_valid & s_ready;
    assign pop       = get_valid & get_ready;

    sync_fifo_ram #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .wr_en   (push),
        .wr_data ({s_last, s_data}),
        .rd_en   (pop),
        .rd_data (head)
    );

    assign get_last = head[DATA_W];
    assign get_data = head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            level       <= '0;
            beat_cnt    <= '0;
            seen_last   <= 1'b0;
            stream_done <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && (beat_cnt != '1)) beat_cnt <= beat_cnt + CNT_W'(1);
            if (push && s_last) seen_last <= 1'b1;
            stream_done <= pop & get_last;
        end
    end

endmodule
